// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared Goertzel constants and onset FSM state type
package goertzel_pkg;

    localparam int POWER_W   = 64;
    localparam int FFT_MAG   = 1024;
    localparam int NORMALIZE = 2 ** 23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ONSET   = 2'd1,
        ST_HOLDOFF = 2'd2
    } onset_state_t;

endpackage

// File: rtl/note_onset_detect_if.sv
// rtl/note_onset_detect_if.sv - frame input, software control and hit event signals
interface note_onset_detect_if #(
    parameter int POWER_W = 64
);
    logic signed [POWER_W-1:0] power;
    logic                      advance;
    logic        [POWER_W-1:0] threshold;
    logic        [7:0]         holdoff_frames;
    logic                      ack;
    logic                      hit_pulse;
    logic                      hit_pending;
    logic                      overrun;
    logic        [POWER_W-1:0] hit_power;
    logic        [15:0]        hit_count;

    modport master (
        output power, advance, threshold, holdoff_frames, ack,
        input  hit_pulse, hit_pending, overrun, hit_power, hit_count
    );

    modport slave (
        input  power, advance, threshold, holdoff_frames, ack,
        output hit_pulse, hit_pending, overrun, hit_power, hit_count
    );

endinterface

// File: rtl/hit_event_reg.sv
// rtl/hit_event_reg.sv - hit strobe, sticky pending/overrun flags, last peak and hit counter
module hit_event_reg #(
    parameter int POWER_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit,
    input  logic [POWER_W-1:0] peak,
    input  logic               ack,
    output logic               hit_pulse,
    output logic               hit_pending,
    output logic               overrun,
    output logic [POWER_W-1:0] hit_power,
    output logic [15:0]        hit_count
);

    logic [15:0] count_q;

    assign hit_count = count_q;

    // A hit always wins over a coincident ack: pending stays set, only overrun is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_pulse   <= 1'b0;
            hit_pending <= 1'b0;
            overrun     <= 1'b0;
            hit_power   <= '0;
            count_q     <= '0;
        end else begin
            hit_pulse <= hit;
            if (hit) begin
                hit_pending <= 1'b1;
                hit_power   <= peak;
                overrun     <= ack ? 1'b0 : (overrun | hit_pending);
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end else if (ack) begin
                hit_pending <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/note_onset_detect.sv
// rtl/note_onset_detect.sv - per-frame onset FSM with peak tracking and release hysteresis
module note_onset_detect #(
    parameter int POWER_W          = 64,
    parameter int MAX_ONSET_FRAMES = 4
) (
    input  logic                clk,
    input  logic                reset,
    note_onset_detect_if.slave  bus
);
    import goertzel_pkg::*;

    localparam int CNT_W = $clog2(MAX_ONSET_FRAMES + 1);

    onset_state_t       state;
    logic [POWER_W-1:0] peak;
    logic [CNT_W-1:0]   onset_cnt;
    logic [7:0]         hold_cnt;

    logic [POWER_W-1:0] power_clamped;
    logic [POWER_W-1:0] release_level;
    logic               enabled;
    logic               grows;
    logic               hit;

    always_comb begin
        power_clamped = bus.power[POWER_W-1] ? '0 : $unsigned(bus.power);
        release_level = bus.threshold >> 1;
        enabled       = (bus.threshold != '0);
        grows         = (power_clamped > peak) &&
                        (onset_cnt < CNT_W'(MAX_ONSET_FRAMES));
        // Decision is made on the deciding frame so the registered pulse lands one cycle later.
        hit           = bus.advance && enabled && (state == ST_ONSET) && !grows;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            peak      <= '0;
            onset_cnt <= '0;
            hold_cnt  <= '0;
        end else if (!enabled) begin
            state <= ST_IDLE;
        end else if (bus.advance) begin
            case (state)
                ST_IDLE: begin
                    if (power_clamped >= bus.threshold) begin
                        state     <= ST_ONSET;
                        peak      <= power_clamped;
                        onset_cnt <= CNT_W'(1);
                    end
                end
                ST_ONSET: begin
                    if (grows) begin
                        peak      <= power_clamped;
                        onset_cnt <= onset_cnt + CNT_W'(1);
                    end else begin
                        hold_cnt <= bus.holdoff_frames;
                        state    <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    // Stay here while the note is still ringing above the release level.
                    if (hold_cnt != 8'd0) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else if (power_clamped < release_level) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hit_event_reg #(
        .POWER_W (POWER_W)
    ) u_event (
        .clk         (clk),
        .reset       (reset),
        .hit         (hit),
        .peak        (peak),
        .ack         (bus.ack),
        .hit_pulse   (bus.hit_pulse),
        .hit_pending (bus.hit_pending),
        .overrun     (bus.overrun),
        .hit_power   (bus.hit_power),
        .hit_count   (bus.hit_count)
    );

endmodule
